// File: rtl/bus_datapath_seq_if.sv
// Request channel and completion status of the sequenced single-bus datapath.
// The requester side uses the master modport, the datapath the slave modport.
interface bus_datapath_seq_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [AW-1:0]    req_ra;
    logic [AW-1:0]    req_rb;
    logic [AW-1:0]    req_rd;
    logic [WIDTH-1:0] req_imm;
    logic             req_use_imm;
    logic             done;
    logic             zf;

    modport master (
        output req_valid, req_op, req_ra, req_rb, req_rd, req_imm, req_use_imm,
        input  req_ready, done, zf
    );

    modport slave (
        input  req_valid, req_op, req_ra, req_rb, req_rd, req_imm, req_use_imm,
        output req_ready, done, zf
    );
endinterface

// File: rtl/bus_datapath_seq.sv
// Single-bus register datapath with an on-block micro-sequencer.
// NREGS general registers plus Y, Z (double width), HI and LO share one
// internal bus. Each accepted request runs a fixed sequence of transfers:
// T_A (Y <= R[ra]), T_B (Z <= ALU(Y, B)), T_WL (low word write-back) and,
// for MUL only, T_WH (HI <= Z high word).
module bus_datapath_seq #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    bus_datapath_seq_if.slave req_if,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [WIDTH-1:0]  dbg_data,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);
    localparam int SHW = $clog2(WIDTH);
    localparam int ZW  = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T_A  = 3'd1,
        S_T_B  = 3'd2,
        S_T_WL = 3'd3,
        S_T_WH = 3'd4
    } state_t;

    // Architectural state
    logic [WIDTH-1:0] regs_r [NREGS];
    logic [WIDTH-1:0] y_r;
    logic [ZW-1:0]    z_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             zf_r;
    logic             done_r;
    logic             ready_r;
    state_t           state_r;

    // Instruction register captured at accept; req_* are not looked at again.
    logic [2:0]       ir_op_r;
    logic [AW-1:0]    ir_ra_r;
    logic [AW-1:0]    ir_rb_r;
    logic [AW-1:0]    ir_rd_r;
    logic [WIDTH-1:0] ir_imm_r;
    logic             ir_use_imm_r;

    // Combinational datapath
    logic             accept_s;
    logic [WIDTH-1:0] bus_s;
    logic [ZW-1:0]    alu_s;
    logic [ZW-1:0]    a_ext_s;
    logic [ZW-1:0]    b_ext_s;
    logic [SHW-1:0]   shamt_s;
    logic             rf_we_s;
    logic [AW-1:0]    rf_waddr_s;
    logic [WIDTH-1:0] rf_wdata_s;

    // Addresses at or above NREGS have no backing register.
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return (int'(addr) < NREGS);
    endfunction

    // Register read that returns zero for unbacked addresses.
    function automatic logic [WIDTH-1:0] reg_read(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        if (addr_in_range(addr)) begin
            val = regs_r[addr];
        end else begin
            val = {WIDTH{1'b0}};
        end
        return val;
    endfunction

    assign accept_s      = req_if.req_valid && ready_r;
    assign req_if.req_ready = ready_r;
    assign req_if.done   = done_r;
    assign req_if.zf     = zf_r;
    assign hi            = hi_r;
    assign lo            = lo_r;
    assign dbg_data      = reg_read(dbg_addr);

    // Internal bus source select, one driver per sequencer step.
    always_comb begin
        bus_s = {WIDTH{1'b0}};
        case (state_r)
            S_T_A:   bus_s = reg_read(ir_ra_r);
            S_T_B:   bus_s = ir_use_imm_r ? ir_imm_r : reg_read(ir_rb_r);
            S_T_WL:  bus_s = z_r[WIDTH-1:0];
            S_T_WH:  bus_s = z_r[ZW-1:WIDTH];
            default: bus_s = {WIDTH{1'b0}};
        endcase
    end

    // ALU: Y against the bus; only MUL populates the high word of Z.
    always_comb begin
        a_ext_s = {{WIDTH{y_r[WIDTH-1]}}, y_r};
        b_ext_s = {{WIDTH{bus_s[WIDTH-1]}}, bus_s};
        shamt_s = bus_s[SHW-1:0];
        alu_s   = {ZW{1'b0}};
        case (ir_op_r)
            OP_ADD:  alu_s = {{WIDTH{1'b0}}, y_r + bus_s};
            OP_SUB:  alu_s = {{WIDTH{1'b0}}, y_r - bus_s};
            OP_AND:  alu_s = {{WIDTH{1'b0}}, y_r & bus_s};
            OP_OR:   alu_s = {{WIDTH{1'b0}}, y_r | bus_s};
            OP_XOR:  alu_s = {{WIDTH{1'b0}}, y_r ^ bus_s};
            OP_SHL:  alu_s = {{WIDTH{1'b0}}, y_r << shamt_s};
            OP_SHR:  alu_s = {{WIDTH{1'b0}}, y_r >> shamt_s};
            // Sign-extended operands make the low 2*WIDTH bits of the
            // unsigned product equal the signed product.
            OP_MUL:  alu_s = a_ext_s * b_ext_s;
            default: alu_s = {ZW{1'b0}};
        endcase
    end

    // Register-file write port arbitration: external load only in IDLE,
    // sequencer write-back only in T_WL of a non-MUL operation.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = wr_addr;
        rf_wdata_s = wr_data;
        if (state_r == S_IDLE) begin
            rf_we_s = wr_en;
        end else if ((state_r == S_T_WL) && (ir_op_r != OP_MUL)) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = ir_rd_r;
            rf_wdata_s = bus_s;
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // General register file; writes to unbacked addresses are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (rf_we_s && addr_in_range(rf_waddr_s)) begin
            regs_r[rf_waddr_s] <= rf_wdata_s;
        end
    end

    // Micro-sequencer with its registered datapath and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            ready_r      <= 1'b1;
            done_r       <= 1'b0;
            zf_r         <= 1'b0;
            y_r          <= {WIDTH{1'b0}};
            z_r          <= {ZW{1'b0}};
            hi_r         <= {WIDTH{1'b0}};
            lo_r         <= {WIDTH{1'b0}};
            ir_op_r      <= 3'd0;
            ir_ra_r      <= {AW{1'b0}};
            ir_rb_r      <= {AW{1'b0}};
            ir_rd_r      <= {AW{1'b0}};
            ir_imm_r     <= {WIDTH{1'b0}};
            ir_use_imm_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        ir_op_r      <= req_if.req_op;
                        ir_ra_r      <= req_if.req_ra;
                        ir_rb_r      <= req_if.req_rb;
                        ir_rd_r      <= req_if.req_rd;
                        ir_imm_r     <= req_if.req_imm;
                        ir_use_imm_r <= req_if.req_use_imm;
                        ready_r      <= 1'b0;
                        state_r      <= S_T_A;
                    end
                end
                S_T_A: begin
                    y_r     <= bus_s;
                    state_r <= S_T_B;
                end
                S_T_B: begin
                    z_r     <= alu_s;
                    zf_r    <= (alu_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    state_r <= S_T_WL;
                end
                S_T_WL: begin
                    if (ir_op_r == OP_MUL) begin
                        lo_r    <= bus_s;
                        state_r <= S_T_WH;
                    end else begin
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        state_r <= S_IDLE;
                    end
                end
                S_T_WH: begin
                    hi_r    <= bus_s;
                    done_r  <= 1'b1;
                    ready_r <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: a 32-bit instance with a non power of
// two register count (so out-of-range addresses exist) and an 8-bit, 4-register
// instance driven back-to-back. Expected results come from a bench-side
// register model and reference ALU, queued at issue and compared at done.
module tb_bus_datapath_seq;
    localparam int W0 = 32, N0 = 12, A0 = 4;
    localparam int W1 = 8,  N1 = 4,  A1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bus_datapath_seq_if #(.WIDTH(W0), .AW(A0)) if0 ();
    bus_datapath_seq_if #(.WIDTH(W1), .AW(A1)) if1 ();

    logic          wr_en0, wr_en1;
    logic [A0-1:0] wr_addr0, dbg_addr0;
    logic [A1-1:0] wr_addr1, dbg_addr1;
    logic [W0-1:0] wr_data0, dbg_data0, hi0, lo0;
    logic [W1-1:0] wr_data1, dbg_data1, hi1, lo1;

    bus_datapath_seq #(.WIDTH(W0), .NREGS(N0), .AW(A0)) dut0 (
        .clk(clk), .reset(reset), .req_if(if0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .dbg_addr(dbg_addr0), .dbg_data(dbg_data0), .hi(hi0), .lo(lo0)
    );

    bus_datapath_seq #(.WIDTH(W1), .NREGS(N1), .AW(A1)) dut1 (
        .clk(clk), .reset(reset), .req_if(if1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .dbg_addr(dbg_addr1), .dbg_data(dbg_data1), .hi(hi1), .lo(lo1)
    );

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rd;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zf;
    } exp_t;

    exp_t        sb_q [$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] mdl0 [16];
    logic [7:0]  mdl1 [N1];

    // Back-to-back sweep table for the 8-bit instance (one entry per op).
    logic [2:0] sw_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [1:0] sw_ra  [8] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1};
    logic [1:0] sw_rb  [8] = '{2'd1, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2};
    logic [1:0] sw_rd  [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd0};
    logic [7:0] sw_imm [8] = '{8'd0, 8'd0, 8'h5A, 8'd0, 8'd0, 8'd11, 8'd13, 8'd0};
    logic       sw_ui  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reference ALU for width w (<=32): returns {hi, lo}.
    function automatic logic [63:0] ref_alu(input int w, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m, ua, ub, r, hv;
        longint sa, sb;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & m;
        ub = {32'd0, b} & m;
        hv = 64'd0;
        case (op)
            3'd0: r = (ua + ub) & m;
            3'd1: r = (ua - ub) & m;
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = (ua << (ub % 64'(w))) & m;
            3'd6: r = ua >> (ub % 64'(w));
            default: begin
                sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
                sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
                r  = 64'(sa * sb);
                hv = (r >> w) & m;
                r  = r & m;
            end
        endcase
        return {hv[31:0], r[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input logic [3:0] a, input logic [31:0] d);
        wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d;
        tick();
        wr_en0 = 1'b0;
        if (int'(a) < N0) mdl0[a] = d;
    endtask

    task automatic load1(input logic [1:0] a, input logic [7:0] d);
        wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d;
        tick();
        wr_en1 = 1'b0;
        mdl1[a] = d;
    endtask

    task automatic rd0_check(input string tag, input logic [3:0] a, input logic [31:0] expv);
        dbg_addr0 = a;
        #1;
        check(tag, dbg_data0, expv);
    endtask

    task automatic sweep0(input string tag);
        for (int i = 0; i < 16; i++) rd0_check(tag, 4'(i), mdl0[i]);
    endtask

    // Issue one request on the 32-bit instance and follow it to completion.
    task automatic issue0(input string tag, input logic [2:0] op,
                          input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                          input logic [31:0] imm, input logic use_imm,
                          input logic sim_wr = 1'b0, input logic [3:0] sim_addr = 4'd0,
                          input logic [31:0] sim_data = 32'd0, input logic late_wr = 1'b0);
        exp_t e;
        logic [31:0] b;
        logic [63:0] r;
        int n;
        if (sim_wr) begin
            wr_en0 = 1'b1; wr_addr0 = sim_addr; wr_data0 = sim_data;
            if (int'(sim_addr) < N0) mdl0[sim_addr] = sim_data;
        end
        b = use_imm ? imm : mdl0[rb];
        r = ref_alu(32, op, mdl0[ra], b);
        e.op = op; e.rd = rd; e.lo = r[31:0]; e.hi = r[63:32]; e.zf = (r[31:0] == 32'd0);
        sb_q.push_back(e);
        check({tag, "_ready_idle"}, if0.req_ready, 1'b1);
        if0.req_valid = 1'b1; if0.req_op = op; if0.req_ra = ra; if0.req_rb = rb;
        if0.req_rd = rd; if0.req_imm = imm; if0.req_use_imm = use_imm;
        tick();
        // Scramble request fields after accept: they must be ignored now.
        if0.req_valid = 1'b0; if0.req_ra = ~ra; if0.req_rb = ~rb; if0.req_rd = ~rd;
        if0.req_imm = ~imm; if0.req_use_imm = ~use_imm; if0.req_op = ~op;
        wr_en0 = 1'b0;
        n = 0;
        while (if0.done !== 1'b1 && n < 12) begin
            check({tag, "_busy"}, if0.req_ready, 1'b0);
            if (late_wr && n == 1) begin
                wr_en0 = 1'b1; wr_addr0 = 4'd10; wr_data0 = 32'hDEAD_BEEF;
            end
            tick();
            n++;
            if (late_wr && n == 2) wr_en0 = 1'b0;
        end
        e = sb_q.pop_front();
        check({tag, "_latency"}, 64'(n), (e.op == 3'd7) ? 64'd4 : 64'd3);
        check({tag, "_ready_at_done"}, if0.req_ready, 1'b1);
        check({tag, "_zf"}, if0.zf, e.zf);
        if (e.op == 3'd7) begin
            check({tag, "_lo"}, lo0, e.lo);
            check({tag, "_hi"}, hi0, e.hi);
            rd0_check({tag, "_rd_kept"}, e.rd, mdl0[e.rd]);
        end else begin
            if (int'(e.rd) < N0) mdl0[e.rd] = e.lo;
            rd0_check({tag, "_rd"}, e.rd, mdl0[e.rd]);
        end
        tick();
        check({tag, "_done_pulse"}, if0.done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [63:0] r;
        logic [7:0] b1;
        longint last_acc;
        int n;
        reset = 1'b0;
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0; dbg_addr0 = 4'd3;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; dbg_addr1 = 2'd0;
        if0.req_valid = 1'b0; if0.req_op = 3'd0; if0.req_ra = '0; if0.req_rb = '0;
        if0.req_rd = '0; if0.req_imm = '0; if0.req_use_imm = 1'b0;
        if1.req_valid = 1'b0; if1.req_op = 3'd0; if1.req_ra = '0; if1.req_rb = '0;
        if1.req_rd = '0; if1.req_imm = '0; if1.req_use_imm = 1'b0;
        for (int i = 0; i < 16; i++) mdl0[i] = 32'd0;
        for (int i = 0; i < N1; i++) mdl1[i] = 8'd0;

        // Reset defaults
        tick(); tick();
        check("rst_ready", if0.req_ready, 1'b1);
        check("rst_done", if0.done, 1'b0);
        check("rst_zf", if0.zf, 1'b0);
        check("rst_hi", hi0, 32'd0);
        check("rst_lo", lo0, 32'd0);
        check("rst_dbg", dbg_data0, 32'd0);
        reset = 1'b1;
        tick();

        // Basic ADD through the handshake
        load0(4'd1, 32'd5);
        load0(4'd2, 32'd7);
        issue0("add", 3'd0, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0);
        rd0_check("add_lit", 4'd3, 32'd12);

        // Wrap to zero sets zf; SUB borrow
        load0(4'd1, 32'hFFFF_FFFF);
        issue0("add_wrap", 3'd0, 4'd1, 4'd0, 4'd4, 32'd1, 1'b1);
        rd0_check("add_wrap_lit", 4'd4, 32'd0);
        check("add_wrap_zf_lit", if0.zf, 1'b1);
        load0(4'd6, 32'd3);
        load0(4'd7, 32'd5);
        issue0("sub", 3'd1, 4'd6, 4'd7, 4'd5, 32'd0, 1'b0);
        rd0_check("sub_lit", 4'd5, 32'hFFFF_FFFE);

        // Logic and shifts
        issue0("and", 3'd2, 4'd1, 4'd0, 4'd9, 32'h0F0F_0F0F, 1'b1);
        issue0("or",  3'd3, 4'd2, 4'd3, 4'd10, 32'd0, 1'b0);
        issue0("xor", 3'd4, 4'd3, 4'd3, 4'd11, 32'd0, 1'b0);
        issue0("shr", 3'd6, 4'd1, 4'd0, 4'd8, 32'd36, 1'b1);
        issue0("shl33", 3'd5, 4'd3, 4'd0, 4'd2, 32'd33, 1'b1);
        rd0_check("shl33_lit", 4'd2, 32'd24);

        // Signed MUL: R[rd] untouched
        load0(4'd1, 32'hFFFF_FFFD);
        load0(4'd2, 32'h0001_0000);
        issue0("mul", 3'd7, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0);
        check("mul_lo_lit", lo0, 32'hFFFD_0000);
        check("mul_hi_lit", hi0, 32'hFFFF_FFFF);

        // External load in the accept cycle; T_A sees the new value
        issue0("simwr", 3'd0, 4'd1, 4'd1, 4'd1, 32'd0, 1'b0, 1'b1, 4'd1, 32'd9);
        rd0_check("simwr_lit", 4'd1, 32'd18);

        // External load during T_B is ignored
        issue0("latewr", 3'd3, 4'd6, 4'd7, 4'd6, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        rd0_check("latewr_ignored", 4'd10, mdl0[10]);

        // Out-of-range destination and source
        issue0("rd_oor", 3'd0, 4'd6, 4'd7, 4'd12, 32'd0, 1'b0);
        issue0("ra_oor", 3'd0, 4'd13, 4'd0, 4'd0, 32'd7, 1'b1);
        rd0_check("ra_oor_lit", 4'd0, 32'd7);
        load0(4'd14, 32'h1234_5678);
        sweep0("regs_after_ops");

        // Back-to-back sweep on the 8-bit instance, req_valid held high
        load1(2'd0, 8'h3C);
        load1(2'd1, 8'hF5);
        load1(2'd2, 8'h81);
        load1(2'd3, 8'h07);
        last_acc = 0;
        if1.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b1 = sw_ui[i] ? sw_imm[i] : mdl1[sw_rb[i]];
            r = ref_alu(8, sw_op[i], {24'd0, mdl1[sw_ra[i]]}, {24'd0, b1});
            e.op = sw_op[i]; e.rd = {2'b00, sw_rd[i]}; e.lo = r[31:0]; e.hi = r[63:32];
            e.zf = (r[31:0] == 32'd0);
            sb_q.push_back(e);
            check("sweep_ready", if1.req_ready, 1'b1);
            if1.req_op = sw_op[i]; if1.req_ra = sw_ra[i]; if1.req_rb = sw_rb[i];
            if1.req_rd = sw_rd[i]; if1.req_imm = sw_imm[i]; if1.req_use_imm = sw_ui[i];
            tick();
            if (i > 0) check("sweep_interval", 64'(cyc - last_acc), 64'd4);
            last_acc = cyc;
            n = 0;
            while (if1.done !== 1'b1 && n < 12) begin
                tick();
                n++;
            end
            if (i == 7) if1.req_valid = 1'b0;
            e = sb_q.pop_front();
            check("sweep_latency", 64'(n), (e.op == 3'd7) ? 64'd4 : 64'd3);
            check("sweep_zf", if1.zf, e.zf);
            if (e.op == 3'd7) begin
                check("sweep_mul_lo", lo1, e.lo[7:0]);
                check("sweep_mul_hi", hi1, e.hi[7:0]);
            end else begin
                mdl1[e.rd[1:0]] = e.lo[7:0];
                dbg_addr1 = e.rd[1:0];
                #1;
                check("sweep_rd", dbg_data1, mdl1[e.rd[1:0]]);
            end
        end
        tick();
        check("sweep_idle", if1.done, 1'b0);

        // Reset in the middle of a MUL after HI/LO were nonzero
        if0.req_valid = 1'b1; if0.req_op = 3'd7; if0.req_ra = 4'd6;
        if0.req_rb = 4'd7; if0.req_rd = 4'd5; if0.req_use_imm = 1'b0;
        tick();
        if0.req_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) mdl0[i] = 32'd0;
        check("rst_mid_hi", hi0, 32'd0);
        check("rst_mid_lo", lo0, 32'd0);
        check("rst_mid_done", if0.done, 1'b0);
        check("rst_mid_ready", if0.req_ready, 1'b1);
        check("rst_mid_zf", if0.zf, 1'b0);
        sweep0("rst_mid_regs");
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        check("post_rst_hi", hi0, 32'd0);
        check("post_rst_lo", lo0, 32'd0);
        check("post_rst_done", if0.done, 1'b0);
        check("post_rst_ready", if0.req_ready, 1'b1);
        sweep0("post_rst_regs");
        dbg_addr1 = 2'd1;
        #1;
        check("post_rst_dut1", dbg_data1, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_datapath_seq.md
# bus_datapath_seq

Parametrised successor to the single-bus register datapath. It holds NREGS general registers of WIDTH bits plus Y, Z (2·WIDTH), HI and LO, all joined by one internal bus. An on-block micro-sequencer replaces the externally driven per-register select/enable strobes. Each operation request arrives over a valid/ready handshake and is executed as a fixed sequence of bus transfers.

## Interface
- WIDTH, 32: datapath width in bits (≥8).
- NREGS, 16: number of general registers (2..64).
- AW, 4: register address width; must equal ceil(log2(NREGS)).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- req_valid  in  1  operation request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- req_ra  in  AW  source A register.
- req_rb  in  AW  source B register.
- req_rd  in  AW  destination register (ignored for MUL).
- req_imm  in  WIDTH  immediate operand.
- req_use_imm  in  1  B operand = req_imm instead of R[rb].
- wr_en  in  1  external register load (memory-data path).
- wr_addr  in  AW  external load address.
- wr_data  in  WIDTH  external load data.
- done  out  1  one-cycle pulse: operation committed.
- zf  out  1  Z low word was zero on the last completed operation.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  WIDTH  combinational R[dbg_addr]; 0 if dbg_addr ≥ NREGS.
- hi, lo  out  WIDTH  HI/LO register contents.

## Operation
- States: IDLE, T_A, T_B, T_WL, T_WH.
- IDLE: req_ready=1. On req_valid&&req_ready, the edge latches op/ra/rb/rd/imm/use_imm into an internal instruction register and moves to T_A.
- T_A: bus = R[ra]; Y <= bus. → T_B.
- T_B: bus = use_imm ? imm : R[rb]; Z <= ALU(Y, bus); zf <= (ALU low word == 0). → T_WL.
- T_WL: bus = Z[WIDTH-1:0]. Non-MUL: R[rd] <= bus, → IDLE. MUL: LO <= bus, → T_WH.
- T_WH: bus = Z[2W-1:WIDTH]; HI <= bus. → IDLE.
- done registers high for exactly one cycle on every transition into IDLE from T_WL/T_WH.
- ALU, all results mod 2^WIDTH unless noted:
  - ADD/SUB: A±B, carry discarded.
  - AND/OR/XOR: bitwise.
  - SHL: logical left by B[log2(WIDTH)-1:0].
  - SHR: logical right by B[log2(WIDTH)-1:0].
  - MUL: signed two's-complement A×B, full 2·WIDTH product.
  - Z high word = 0 for every op except MUL.
- Out-of-range addresses (≥NREGS): reads return 0; writes are dropped.
- External load: wr_en writes R[wr_addr] at the edge, only while the state is IDLE; wr_en in any other state is ignored.
- An external load and a request accept in the same IDLE cycle are both honoured. T_A samples the newly written value.
- A sequencer write and an external write never coincide, because wr_en is gated to IDLE.
- reset low at any time: state → IDLE. All registers, Y, Z, HI, LO, zf and done clear to 0. An in-flight operation is abandoned with no destination write.

## Timing
- Reset values: req_ready=1 (IDLE), done=0, zf=0, hi=lo=0, dbg_data=0.
- Non-MUL, request accepted at edge k:
  - R[rd] is updated at edge k+3.
  - done and req_ready are high during cycle k+3..k+4.
  - Next accept is possible at edge k+4, giving one operation per 4 cycles.
- MUL, accepted at edge k:
  - LO is updated at edge k+3 and HI at edge k+4.
  - done is high during cycle k+4..k+5.
  - Throughput is one MUL per 5 cycles.
- req_ready drops the cycle after accept and stays low until the cycle done is high.
- req_* inputs are don't-care outside the accept cycle.
- rd = ra or rd = rb is legal: sources are sampled before the write.
- dbg_data, hi and lo reflect register state with zero-cycle combinational read.

## Test plan
- Reset/defaults: pulse reset low mid-way through a MUL after HI/LO were previously nonzero.
  - hi=lo=0, done=0, req_ready=1.
  - R[*]=0 via dbg, no pending write occurs.
- ADD via handshake: load R1=5, R2=7; request ADD ra=1 rb=2 rd=3 at edge k.
  - R3=12 at edge k+3, done pulse of 1 cycle, zf=0.
- Wrap and zero flag: R1=0xFFFFFFFF, ADD imm=1 into R4 → R4=0, zf=1.
  - SUB R5=3−5 → 0xFFFFFFFE.
- MUL signed: R1=−3, R2=0x10000 → LO=0xFFFD0000, HI=0xFFFFFFFF.
  - done at cycle k+4, R[rd] unchanged.
- Simultaneous/edge cases:
  - wr_en R1=9 in the same cycle as an accept of ADD R1+R1→R1 → R1=18.
  - wr_en during T_B is ignored.
  - rd=NREGS write is dropped.
  - SHL by 33 with WIDTH=32 shifts by 1.
- Parameter sweep: WIDTH=8, NREGS=4, AW=2, back-to-back requests with req_valid held high.
  - One accept every 4 cycles.
  - All 8 ops match the reference model.
